ysyx_24110015_mem_arbiter: RTL

Two-master, one-slave memory arbiter for the multi-cycle core. Shares a single memory port between the IFU (instruction fetch, read-only) and the LSU (data load/store), with round-robin tie-break, one outstanding transaction at a time, and a response timeout. Sits between the IFU/LSU and the memory model. The requesters' end-of-access pulses (`*_resp_valid`) feed the core controller.

---
 rtl/ysyx_24110015_mem_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_24110015_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24110015_mem_arbiter
//
// Shares one memory port between the instruction fetch unit (read-only) and
// the load/store unit. One transaction is in flight at a time. Ties are broken
// round-robin, and a response timeout returns an error to the owner if memory
// goes silent.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   ifu_req_valid/ready       IFU request handshake, ifu_addr = fetch address
//   ifu_resp_valid            one-cycle pulse ending an IFU access
//   ifu_rdata, ifu_resp_err   registered IFU response data / error flag
//   lsu_req_valid/ready       LSU request handshake
//   lsu_wen, lsu_addr,
//   lsu_wdata, lsu_wmask      LSU payload (lsu_wen = 1 means write)
//   lsu_resp_valid            one-cycle pulse ending an LSU access
//   lsu_rdata, lsu_resp_err   registered LSU response data / error flag
//   mem_req_valid/ready       memory request handshake
//   mem_wen, mem_addr,
//   mem_wdata, mem_wmask      latched payload of the current owner
//   mem_resp_valid,
//   mem_rdata, mem_resp_err   memory response (sampled only in RESP)
//   arb_busy                  high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module ysyx_24110015_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_wen,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp_err,

    output logic                arb_busy
);

    localparam int          MASK_W      = DATA_W / 8;
    localparam logic [15:0] TIMEOUT_CNT = TIMEOUT[15:0];
    localparam bit          TIMEOUT_EN  = (TIMEOUT != 0);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t              state;
    state_t              stateNext;
    logic                owner;
    logic                last;
    logic [15:0]         count;
    logic [15:0]         countInc;
    logic [ADDR_W-1:0]   addrQ;
    logic                wenQ;
    logic [DATA_W-1:0]   wdataQ;
    logic [MASK_W-1:0]   wmaskQ;

    logic                ifuSel;
    logic                lsuSel;
    logic                accept;
    logic                respDone;
    logic                timeoutFire;

    // Round-robin selection: a lone requester always wins; on a tie the
    // master that was not granted last time goes first (last = 1 means LSU).
    assign ifuSel = ifu_req_valid && (!lsu_req_valid || last);
    assign lsuSel = lsu_req_valid && (!ifu_req_valid || !last);
    assign accept = (state == IDLE) && (ifuSel || lsuSel);

    // The counter saturates rather than wrapping. The timeout fires in the
    // cycle whose incremented count reaches TIMEOUT, so the error pulse lands
    // TIMEOUT+1 cycles after the accept. A real response in that same cycle
    // takes priority over the timeout.
    assign countInc    = (count == 16'hFFFF) ? count : count + 16'd1;
    assign respDone    = (state == RESP) && mem_resp_valid;
    assign timeoutFire = TIMEOUT_EN && (state != IDLE) &&
                         (countInc == TIMEOUT_CNT) && !respDone;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: accept in IDLE, wait for mem ready in REQ, wait for
    // the response in RESP; a timeout drops back to IDLE from either phase.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept) stateNext = REQ;
            REQ: begin
                if (timeoutFire)        stateNext = IDLE;
                else if (mem_req_ready) stateNext = RESP;
            end
            RESP: if (respDone || timeoutFire) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output logic: ready is purely combinational on state, last and the two
    // valids; the memory payload always comes from the latch so it cannot
    // move while memory applies backpressure.
    always_comb begin
        ifu_req_ready = (state == IDLE) && ifuSel;
        lsu_req_ready = (state == IDLE) && lsuSel;
        mem_req_valid = (state == REQ);
        mem_wen       = wenQ;
        mem_addr      = addrQ;
        mem_wdata     = wdataQ;
        mem_wmask     = wmaskQ;
        arb_busy      = (state != IDLE);
    end

    // Grant bookkeeping, payload latch, timeout counter and the registered
    // response outputs. IFU payloads are forced to a plain read. Only the
    // owner's response registers change; the other master's hold their value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner          <= 1'b0;
            last           <= 1'b1;
            count          <= 16'd0;
            addrQ          <= '0;
            wenQ           <= 1'b0;
            wdataQ         <= '0;
            wmaskQ         <= '0;
            ifu_resp_valid <= 1'b0;
            ifu_rdata      <= '0;
            ifu_resp_err   <= 1'b0;
            lsu_resp_valid <= 1'b0;
            lsu_rdata      <= '0;
            lsu_resp_err   <= 1'b0;
        end else begin
            ifu_resp_valid <= 1'b0;
            lsu_resp_valid <= 1'b0;

            if (accept) begin
                owner  <= lsuSel;
                last   <= lsuSel;
                count  <= 16'd0;
                addrQ  <= lsuSel ? lsu_addr : ifu_addr;
                wenQ   <= lsuSel && lsu_wen;
                wdataQ <= lsuSel ? lsu_wdata : '0;
                wmaskQ <= lsuSel ? lsu_wmask : '0;
            end else if (state != IDLE) begin
                count <= countInc;
            end

            if (respDone || timeoutFire) begin
                if (owner) begin
                    lsu_resp_valid <= 1'b1;
                    lsu_rdata      <= respDone ? mem_rdata : '0;
                    lsu_resp_err   <= respDone ? mem_resp_err : 1'b1;
                end else begin
                    ifu_resp_valid <= 1'b1;
                    ifu_rdata      <= respDone ? mem_rdata : '0;
                    ifu_resp_err   <= respDone ? mem_resp_err : 1'b1;
                end
            end
        end
    end

endmodule
